// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes used by decode and by the HI/LO unit,
// plus the HI/LO multiply/divide state encoding.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } hi_lo_state_t;

  // Two's-complement magnitude of a 32-bit value. 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    mag32 = v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hi_lo_mult_div_sign_fixup.sv
// Combinational sign correction: turns the unsigned multiply/divide result
// held by the iteration datapath into the architectural HI/LO values.
module hi_lo_mult_div_sign_fixup #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod_mag,
  input  logic [WIDTH-1:0]   quot_mag,
  input  logic [WIDTH-1:0]   rem_mag,
  input  logic [WIDTH-1:0]   orig_a,
  input  logic               neg_a,
  input  logic               neg_b,
  input  logic               is_signed,
  input  logic               is_div,
  input  logic               div_zero,
  output logic [WIDTH-1:0]   hi_res,
  output logic [WIDTH-1:0]   lo_res
);

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_neg;
  logic [WIDTH-1:0]   rem_neg;
  logic               signs_differ;

  assign prod_neg     = ~prod_mag + {{(2*WIDTH-1){1'b0}}, 1'b1};
  assign quot_neg     = ~quot_mag + {{(WIDTH-1){1'b0}}, 1'b1};
  assign rem_neg      = ~rem_mag + {{(WIDTH-1){1'b0}}, 1'b1};
  assign signs_differ = is_signed & (neg_a ^ neg_b);

  // Select product, divide-by-zero pattern, or signed quotient/remainder.
  always_comb begin
    hi_res = '0;
    lo_res = '0;
    if (!is_div) begin
      {hi_res, lo_res} = signs_differ ? prod_neg : prod_mag;
    end else if (div_zero) begin
      // Divide by zero: all-ones quotient, dividend passed through untouched.
      lo_res = '1;
      hi_res = orig_a;
    end else begin
      lo_res = signs_differ ? quot_neg : quot_mag;
      // Remainder follows the dividend's sign.
      hi_res = (is_signed && neg_a) ? rem_neg : rem_mag;
    end
  end

endmodule

// File: rtl/hi_lo_mult_div.sv
// Iterative multiply/divide unit owning the HI and LO registers.
// Handshake: start is sampled on a rising edge and accepted only while busy
// is low (state IDLE); while busy it is ignored and never queued. MULT/DIV
// codes raise busy for 33 cycles, then done pulses for one cycle with HI/LO
// already committed; a new start may be accepted in that same done cycle.
// MTHI/MTLO write in the accepting edge without raising busy or done.
module hi_lo_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       ALU_function,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mips_pkg::*;

  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  // state_q is the observable FSM state for checkers.
  hi_lo_state_t       state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // acc_q: 64-bit product accumulator; low 33 bits are the partial remainder
  // during a divide.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // op_a_q: multiplicand magnitude, or dividend shifting out / quotient in.
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  // op_b_q: multiplier shifting right, or divisor magnitude.
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   orig_a_q, orig_a_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               signed_q, signed_d;
  logic               is_div_q, is_div_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               op_signed;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set; the whole accumulator then shifts right.
  assign mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (op_b_q[0] ? {1'b0, op_a_q} : {(WIDTH+1){1'b0}});

  // Restoring step: bring in the next dividend bit and trial-subtract.
  assign div_shift = {acc_q[WIDTH-1:0], op_a_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, op_b_q};
  assign div_ok    = ~div_diff[WIDTH+1];

  assign op_signed = (ALU_function == FUNCT_MULT) || (ALU_function == FUNCT_DIV);

  hi_lo_mult_div_sign_fixup #(.WIDTH(WIDTH)) u_fixup (
    .prod_mag  (acc_q),
    .quot_mag  (op_a_q),
    .rem_mag   (acc_q[WIDTH-1:0]),
    .orig_a    (orig_a_q),
    .neg_a     (neg_a_q),
    .neg_b     (neg_b_q),
    .is_signed (signed_q),
    .is_div    (is_div_q),
    .div_zero  (div_zero_q),
    .hi_res    (fix_hi),
    .lo_res    (fix_lo)
  );

  // Next-state and datapath: accept in IDLE, iterate, then commit in FIXUP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    orig_a_d   = orig_a_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    signed_d   = signed_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (ALU_function)
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
              signed_d   = op_signed;
              op_a_d     = op_signed ? mag32(operand_A) : operand_A;
              op_b_d     = op_signed ? mag32(operand_B) : operand_B;
              neg_a_d    = op_signed & operand_A[WIDTH-1];
              neg_b_d    = op_signed & operand_B[WIDTH-1];
              orig_a_d   = operand_A;
              is_div_d   = (ALU_function == FUNCT_DIV) || (ALU_function == FUNCT_DIVU);
              div_zero_d = is_div_d && (operand_B == '0);
              acc_d      = '0;
              cnt_d      = CNT_LOAD;
              state_d    = is_div_d ? ST_DIV : ST_MULT;
            end
            FUNCT_MTHI: hi_d = operand_A;
            FUNCT_MTLO: lo_d = operand_A;
            default: ;
          endcase
        end
      end
      ST_MULT: begin
        acc_d  = {mult_sum, acc_q[WIDTH-1:1]};
        op_b_d = {1'b0, op_b_q[WIDTH-1:1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIXUP;
      end
      ST_DIV: begin
        acc_d  = {{(WIDTH-1){1'b0}}, (div_ok ? div_diff[WIDTH:0] : div_shift)};
        op_a_d = {op_a_q[WIDTH-2:0], div_ok};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      orig_a_q   <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      signed_q   <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      orig_a_q   <= orig_a_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      signed_q   <= signed_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
